// File: rtl/sd_sched_pkg.sv
// Shared definitions for the SD sector write scheduler: FSM encoding,
// default sizing and a small width helper.
package sd_sched_pkg;

  localparam int DEF_SECTOR_WORDS = 256;
  localparam int DEF_FIFO_DEPTH   = 512;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    XFER,
    WAIT_DONE
  } sched_state_e;

  // Address width that stays at least 1 bit for degenerate depths.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_w16.sv
// 16-bit first-word-fall-through FIFO with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo_w16
  import sd_sched_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW   = clog2_min1(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          push_i,
  input  logic [15:0]   din_i,
  input  logic          pop_i,
  output logic [15:0]   dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  // Head is read combinationally so the consumer sees it without a request cycle.
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sd_sector_write_sched.sv
// Packs UART bytes into big-endian 16-bit words, buffers them and schedules
// full (or flushed, zero-padded) sector writes to an SD writer.
module sd_sector_write_sched
  import sd_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          SECTOR_WORDS = DEF_SECTOR_WORDS,
  parameter int          FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_flag,
  input  logic [7:0]  rx_data,
  input  logic        flush,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        overflow,
  output logic        sched_busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = $clog2(SECTOR_WORDS + 1);
  localparam logic [CW-1:0] SW_C = CW'(SECTOR_WORDS);
  localparam logic [KW-1:0] SW_K = KW'(SECTOR_WORDS);

  sched_state_e  state_q, state_d;
  logic [7:0]    hi_byte_q;
  logic          odd_q;
  logic [15:0]   word_q;
  logic          word_vld_q;
  logic          flush_pend_q;
  logic [KW-1:0] n_q;
  logic [KW-1:0] k_q;
  logic [31:0]   wr_addr_q;
  logic [15:0]   wr_data_q;
  logic          overflow_q;

  logic          pad_odd;
  logic          flush_clr;
  logic          xfer_req;
  logic          sector_done;
  logic          fifo_pop;
  logic [15:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [KW-1:0] n_d;

  sync_fifo_w16 #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .srst_i  (sys_rst),
    .push_i  (word_vld_q),
    .din_i   (word_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign n_d = (fifo_count >= SW_C) ? SW_K : KW'(fifo_count);

  always_comb begin
    state_d     = state_q;
    pad_odd     = 1'b0;
    flush_clr   = 1'b0;
    xfer_req    = 1'b0;
    sector_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count >= SW_C) begin
          state_d = START;
        end else if (flush_pend_q) begin
          // A held odd byte is padded and must land in the FIFO before the
          // sector length is taken; an incoming byte completes it instead.
          if (odd_q) begin
            pad_odd = !rx_flag;
          end else if (!word_vld_q) begin
            if (fifo_empty) begin
              flush_clr = 1'b1;
            end else begin
              state_d = START;
            end
          end
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wr_busy) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (!wr_busy) begin
          sector_done = 1'b1;
          state_d     = IDLE;
        end else begin
          xfer_req = wr_req && (k_q < SW_K);
          if (k_q == SW_K) begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (!wr_busy) begin
          sector_done = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Words past the latched length are padding and leave the FIFO untouched.
  assign fifo_pop = xfer_req && (k_q < n_q);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      hi_byte_q    <= '0;
      odd_q        <= 1'b0;
      word_q       <= '0;
      word_vld_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      n_q          <= '0;
      k_q          <= '0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_vld_q <= 1'b0;
      if (rx_flag) begin
        if (odd_q) begin
          word_q     <= {hi_byte_q, rx_data};
          word_vld_q <= 1'b1;
          odd_q      <= 1'b0;
        end else begin
          hi_byte_q <= rx_data;
          odd_q     <= 1'b1;
        end
      end else if (pad_odd) begin
        word_q     <= {hi_byte_q, 8'h00};
        word_vld_q <= 1'b1;
        odd_q      <= 1'b0;
      end
      if (word_vld_q && fifo_full) begin
        overflow_q <= 1'b1;
      end
      if (flush) begin
        flush_pend_q <= 1'b1;
      end else if (flush_clr || sector_done) begin
        flush_pend_q <= 1'b0;
      end
      if (state_q == START) begin
        n_q <= n_d;
        k_q <= '0;
      end
      if (xfer_req) begin
        k_q       <= k_q + KW'(1);
        wr_data_q <= (k_q < n_q) ? fifo_head : 16'h0000;
      end
      if (sector_done) begin
        wr_addr_q <= wr_addr_q + 32'd1;
      end
    end
  end

  assign wr_en      = (state_q == START);
  assign sched_busy = (state_q != IDLE);
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/sd_sector_write_sched.md
SD_SECTOR_WRITE_SCHED -- requirements
Module: sd_sector_write_sched

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0: first SD sector address written after reset.
REQ-002 The block SHALL have parameter SECTOR_WORDS, default 256: 16-bit words per sector (512 bytes).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 512: word buffer depth (two sectors).
REQ-004 The block SHALL have port sys_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port rx_flag, input, 1: one-cycle strobe, rx_data valid.
REQ-007 The block SHALL have port rx_data, input, 8: received UART byte.
REQ-008 The block SHALL have port flush, input, 1: one-cycle request to write the current partial sector.
REQ-009 The block SHALL have port wr_busy, input, 1: SD writer busy with a sector.
REQ-010 The block SHALL have port wr_req, input, 1: SD writer requests the next data word.
REQ-011 The block SHALL have port wr_en, output, 1: one-cycle sector write start pulse.
REQ-012 The block SHALL have port wr_addr, output, 32: sector address, stable from wr_en until wr_busy falls.
REQ-013 The block SHALL have port wr_data, output, 16: data word to the SD writer.
REQ-014 The block SHALL have port overflow, output, 1: sticky, set when a word is dropped.
REQ-015 The block SHALL have port sched_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 Byte packing SHALL be big-endian: the first byte of a pair goes to [15:8], the second to [7:0], and the completed word is pushed into the FIFO in the cycle after the second rx_flag.
REQ-017 The FSM SHALL have the states IDLE, START, WAIT_BUSY, XFER and WAIT_DONE.
REQ-018 In IDLE, the FSM SHALL go to START when FIFO count >= SECTOR_WORDS or a flush is pending (pending flush with an empty FIFO and no odd byte: the flush is cleared, no write).
REQ-019 On a flush, any held odd byte SHALL be pushed as {byte, 8'h00} before the sector length is latched.
REQ-020 In START, the block SHALL assert wr_en for exactly 1 cycle, latch n = min(count, SECTOR_WORDS), and go to WAIT_BUSY.
REQ-021 In WAIT_BUSY, the FSM SHALL go to XFER when wr_busy = 1.
REQ-022 In XFER, on each wr_req the block SHALL increment word index k and, in the next cycle, set wr_data to the FIFO head (popped) if k < n, else 16'h0000 (pad).
REQ-023 When wr_busy falls (in XFER or WAIT_DONE), the block SHALL set wr_addr <= wr_addr + 1 (wrapping modulo 2^32), clear the flush pending flag, and return to IDLE.
REQ-024 A flush SHALL be latched as pending whenever it arrives (including in a non-IDLE state) and SHALL be served at the next IDLE evaluation.
REQ-025 Byte reception SHALL continue in all states; simultaneous push and pop SHALL leave the count unchanged.
REQ-026 If the FIFO is full when a word completes, the word SHALL be dropped, overflow set to 1, and the count unchanged.
REQ-027 A wr_req with k >= SECTOR_WORDS SHALL be ignored (wr_data holds its value).

Reset
REQ-028 On sys_rst=1 at a clock edge: state IDLE, wr_addr=BASE_ADDR, wr_en=0, wr_data=0, overflow=0, FIFO emptied, odd-byte, flush-pending and k cleared.
REQ-029 Reset mid-sector SHALL abort without further wr_en; the SD writer's own reset handles its side.

Structure
REQ-030 The FSM state encoding and the SECTOR_WORDS/FIFO_DEPTH defaults SHALL live in shared package sd_sched_pkg.
REQ-031 The word buffer SHALL be a sub-module sync_fifo_w16: first-word-fall-through, synchronous reset, with count output.

Verification
REQ-032 512 bytes 0x00..0xFF twice -> one wr_en, wr_addr=0, 256 words 0x0001, 0x0203, ..., 0xFEFF, then wr_addr=1.
REQ-033 3 bytes AA,BB,CC, then flush -> one sector: 0xAABB, 0xCC00, followed by 254 words of 0x0000.
REQ-034 1024 bytes streamed with no gap while sector 0 is being written -> two sectors at addresses 0 and 1, overflow=0.
REQ-035 wr_busy held high so the FIFO is full, then 2 more bytes -> overflow=1, count stays 512, data already stored is intact.
REQ-036 sys_rst asserted at k=100 -> the next cycle is IDLE, wr_addr=BASE_ADDR, and no wr_en occurs until 256 new words arrive.
REQ-037 BASE_ADDR=32'hFFFFFFFF, two sectors -> addresses 0xFFFFFFFF and then 0x00000000.
